chunked_serial_adder: RTL and testbench
=======================================

CHUNKED_SERIAL_ADDER -- requirements
Module: chunked_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 SHALL have port sub  input  1  mode: 0 = add, 1 = subtract; latched with start.
REQ-007 SHALL have port a  input  WIDTH  first operand; latched with start.
REQ-008 SHALL have port b  input  WIDTH  second operand; latched with start.
REQ-009 SHALL have port cin  input  1  carry-in (add) or borrow-in (subtract); latched with start.
REQ-010 SHALL have port busy  output  1  high while chunks are being processed.
REQ-011 SHALL have port done  output  1  single-cycle pulse: result valid.
REQ-012 SHALL have port s  output  WIDTH  registered sum/difference.
REQ-013 SHALL have port co  output  1  carry-out (add) or no-borrow (subtract).
REQ-014 SHALL have port ov  output  1  two's-complement signed overflow.

Function
REQ-015 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-016 In IDLE, start=1 at edge k SHALL latch a, b, sub and cin, clear the chunk counter, and move to BUSY.
REQ-017 In IDLE, start=0 SHALL keep the FSM in IDLE.
REQ-018 In BUSY, each edge SHALL add chunk i (bits i*CHUNK+CHUNK-1 : i*CHUNK, LSB chunk first) with a registered inter-chunk carry, then increment i.
REQ-019 Carry into chunk 0 SHALL be cin when sub=0 and ~cin when sub=1.
REQ-020 The b operand SHALL be used as b when sub=0 and as ~b when sub=1, so sub=1 computes a - b - cin modulo 2^WIDTH.
REQ-021 At edge k+NCHUNK, the last chunk SHALL complete, s/co/ov SHALL update together, and the FSM SHALL move to DONE.
REQ-022 co SHALL be the carry out of bit WIDTH-1; ov SHALL be the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-023 done SHALL be 1 only while in DONE, i.e. for exactly one cycle after edge k+NCHUNK; DONE SHALL return to IDLE on the next edge unconditionally.
REQ-024 busy SHALL be 1 exactly while in BUSY (cycles after edges k .. k+NCHUNK-1).
REQ-025 s, co and ov SHALL hold the previous result throughout BUSY and SHALL hold the new result until the next operation completes.
REQ-026 start in BUSY or DONE SHALL be ignored: no re-latch and no queuing.
REQ-027 Operand input changes after the latch edge SHALL NOT affect the result.
REQ-028 When CHUNK = WIDTH (NCHUNK=1), the FSM SHALL spend one cycle in BUSY and produce done after edge k+1.
REQ-029 Throughput SHALL be one operation per NCHUNK+2 cycles, with start held high continuously.

Reset
REQ-030 rst_n=0 SHALL immediately, without a clock, force IDLE and set busy=0, done=0, s=0, co=0 and ov=0, and clear all internal registers.
REQ-031 Reset asserted mid-operation SHALL abort the operation with no done pulse; after release the FSM SHALL wait in IDLE for a new start.

Verification (WIDTH=16, CHUNK=4 unless noted)
REQ-032 add a=0x0001, b=0x0003, cin=0 -> s=0x0004, co=0, ov=0; busy high 4 cycles; done pulses once, 4 cycles after the start edge.
REQ-033 add a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, co=1, ov=0; add a=0x7FFF, b=0x0000, cin=1 -> s=0x8000, co=0, ov=1.
REQ-034 sub a=0x0005, b=0x0003, cin=0 -> s=0x0002, co=1; sub a=0x0003, b=0x0005, cin=0 -> s=0xFFFE, co=0, ov=0; sub a=0x8000, b=0x0001, cin=0 -> s=0x7FFF, ov=1.
REQ-035 start pulsed during BUSY with different operands -> ignored; first result unchanged; exactly one done pulse.
REQ-036 rst_n dropped for 1 cycle after 2 BUSY cycles -> all outputs 0 at once, no done pulse; a new start then completes normally.
REQ-037 WIDTH=8, CHUNK=8: a=0xF0, b=0x0F, cin=1 -> s=0x00, co=1; done after edge k+1.

Source files
------------

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB chunk first.
// The carry between chunks lives in a register; results update once at the end.
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               c_q, c_d;
  logic               co_q, co_d;
  logic               ov_q, ov_d;

  logic [CHUNK:0]       add_w;
  logic [WIDTH+CHUNK-1:0] cat_w;
  logic                 msb_cin;

  // Next-state and datapath: operands shift right, sums shift in at the top.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    co_d    = co_q;
    ov_d    = ov_q;
    add_w   = {1'b0, a_q[CHUNK-1:0]}
            + {1'b0, b_q[CHUNK-1:0]}
            + {{CHUNK{1'b0}}, c_q};
    cat_w   = {add_w[CHUNK-1:0], acc_q};
    // Carry into the top bit, recovered from the sum bit of the last chunk.
    msb_cin = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ add_w[CHUNK-1];
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = sub ? ~cin : cin;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_d   = a_q >> CHUNK;
        b_d   = b_q >> CHUNK;
        c_d   = add_w[CHUNK];
        acc_d = cat_w[WIDTH+CHUNK-1:CHUNK];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          s_d     = cat_w[WIDTH+CHUNK-1:CHUNK];
          co_d    = add_w[CHUNK];
          ov_d    = msb_cin ^ add_w[CHUNK];
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and result registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign co   = co_q;
  assign ov   = ov_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder: 16/4 instance with a result scoreboard,
// plus an 8/8 instance for the single-chunk case.
module tb_chunked_serial_adder;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, co, ov;
  logic [15:0] s;

  logic        start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, co8, ov8;
  logic [7:0]  s8;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
    .a(a), .b(b), .cin(cin), .busy(busy), .done(done),
    .s(s), .co(co), .ov(ov)
  );

  chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8),
    .a(a8), .b(b8), .cin(cin8), .busy(busy8), .done(done8),
    .s(s8), .co(co8), .ov(ov8)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic m, input logic c);
    logic [16:0] r;
    exp_t e;
    if (!m) r = {1'b0, x} + {1'b0, y} + {16'd0, c};
    else    r = {1'b0, x} - {1'b0, y} - {16'd0, c};
    e.s  = r[15:0];
    e.co = m ? ~r[16] : r[16];
    if (!m) e.ov = (x[15] == y[15]) && (r[15] != x[15]);
    else    e.ov = (x[15] != y[15]) && (r[15] != x[15]);
    return e;
  endfunction

  task automatic pop_chk(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_q_empty"}, 1, 0);
    end else begin
      e = q.pop_front();
      chk({tag, "_s"}, {16'd0, s}, {16'd0, e.s});
      chk({tag, "_co"}, {31'd0, co}, {31'd0, e.co});
      chk({tag, "_ov"}, {31'd0, ov}, {31'd0, e.ov});
    end
  endtask

  // One operation; poke=1 fires a second start with other operands mid-BUSY.
  task automatic op16(input string tag, input logic [15:0] ta,
                      input logic [15:0] tb, input logic tsub,
                      input logic tcin, input logic poke);
    int bcnt, dpos, dcnt;
    logic [15:0] prev;
    @(negedge clk);
    a = ta; b = tb; sub = tsub; cin = tcin; start = 1'b1;
    q.push_back(model(ta, tb, tsub, tcin));
    prev = s;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    sub = ~tsub; cin = ~tcin;
    bcnt = 0; dpos = -1; dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (dpos < 0) begin
          dpos = i;
          pop_chk(tag);
        end
      end
      if (i == 2) chk({tag, "_hold"}, {16'd0, s}, {16'd0, prev});
      if (poke && i == 1) begin
        start = 1'b1; a = 16'h1234; b = 16'h4321;
      end
      if (poke && i == 3) start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({tag, "_busy_cycles"}, bcnt, 4);
    chk({tag, "_done_pos"}, dpos, 4);
    chk({tag, "_done_cnt"}, dcnt, 1);
  endtask

  initial begin
    int d1, d2, nd, nb;
    #2;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_s", {16'd0, s}, 0);
    chk("rst_co_ov", {30'd0, co, ov}, 0);
    @(negedge clk); rst_n = 1'b1;

    op16("add_small", 16'h0001, 16'h0003, 1'b0, 1'b0, 1'b0);
    chk("add_small_const", {16'd0, s}, 32'h0004);
    op16("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    op16("add_ov", 16'h7FFF, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk("add_ov_const", {15'd0, s, ov}, {15'd0, 16'h8000, 1'b1});
    op16("sub_pos", 16'h0005, 16'h0003, 1'b1, 1'b0, 1'b0);
    op16("sub_neg", 16'h0003, 16'h0005, 1'b1, 1'b0, 1'b0);
    chk("sub_neg_const", {14'd0, s, co, ov}, {14'd0, 16'hFFFE, 2'b00});
    op16("sub_ov", 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
    op16("sub_bin", 16'h1234, 16'h0234, 1'b1, 1'b1, 1'b0);
    op16("add_mix", 16'hA5C3, 16'h5A3D, 1'b0, 1'b1, 1'b0);
    op16("poke", 16'h0100, 16'h0023, 1'b0, 1'b0, 1'b1);

    // Reset mid-operation.
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_busy_before", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_s", {16'd0, s}, 0);
    chk("abort_co_ov", {30'd0, co, ov}, 0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    nd = 0; nb = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
      if (busy) nb++;
    end
    chk("abort_no_done", nd, 0);
    chk("abort_idle", nb, 0);
    op16("after_rst", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b0);

    // Back-to-back with start held high.
    @(negedge clk);
    a = 16'h00FF; b = 16'h0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
    q.push_back(model(16'h00FF, 16'h0001, 1'b0, 1'b0));
    q.push_back(model(16'h00FF, 16'h0001, 1'b0, 1'b0));
    d1 = -1; d2 = -1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (d1 < 0) begin d1 = i; pop_chk("tput1"); end
        else if (d2 < 0) begin d2 = i; pop_chk("tput2"); end
      end
    end
    start = 1'b0;
    chk("tput_first", d1, 4);
    chk("tput_gap", d2 - d1, 6);
    repeat (8) @(posedge clk);

    // Single-chunk instance.
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0; a8 = 8'h11;
    chk("w8_busy", {30'd0, busy8, done8}, 2'b10);
    @(posedge clk); #1;
    chk("w8_done", {30'd0, busy8, done8}, 2'b01);
    chk("w8_s", {24'd0, s8}, 32'h00);
    chk("w8_co_ov", {30'd0, co8, ov8}, 2'b10);
    @(posedge clk); #1;
    chk("w8_idle", {30'd0, busy8, done8}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
